multi_delta_counter: RTL and testbench
======================================

// Module: multi_delta_counter
//
// PURPOSE
//   Bank of NUM_CH independent up/down counters, each with a per-cycle variable delta.
//   Each channel has sticky overflow/underflow flags and a registered threshold-crossing pulse.
//   Used for multi-source event accounting (credits, byte counts, perf counters) behind a
//   register interface, replacing banks of single-channel delta counters.
//
// PARAMETERS
//   NUM_CH  4   number of independent channels (>=1)
//   WIDTH   8   counter, delta, load and threshold width per channel (>=1)
//
// PORTS
//   Clocking: one clock; reset is asynchronous and active-high.
//   clk_i      in   1              clock, all state updates on rising edge
//   rst_i      in   1              asynchronous active-high reset
//   clr_all_i  in   1              synchronous clear of every channel and flag
//   clear_i    in   NUM_CH         per-channel synchronous clear
//   load_i     in   NUM_CH         per-channel load of d_i slice
//   en_i       in   NUM_CH         per-channel count enable
//   down_i     in   NUM_CH         1 = subtract delta, 0 = add delta
//   delta_i    in   NUM_CH*WIDTH   per-channel delta, channel c at [c*WIDTH +: WIDTH]
//   d_i        in   NUM_CH*WIDTH   per-channel load value, same packing
//   thr_i      in   NUM_CH*WIDTH   per-channel threshold, same packing
//   q_o        out  NUM_CH*WIDTH   per-channel count, same packing
//   ovf_o      out  NUM_CH         sticky overflow flag (up-count carry out)
//   unf_o      out  NUM_CH         sticky underflow flag (down-count borrow)
//   thr_hit_o  out  NUM_CH         one-cycle pulse on upward threshold crossing
//
// BEHAVIOUR
//   - Reset: q_o, ovf_o, unf_o and thr_hit_o are all 0. Reset acts immediately, also
//     mid-operation; counting resumes on the first clock edge after release.
//   - Channel priority per cycle: clr_all_i > clear_i[c] > load_i[c] > en_i[c] > hold.
//   - Latency: q_o, ovf_o and unf_o reflect the selected action one cycle later (registered).
//   - Clear and clr_all: count becomes 0, ovf and unf become 0, and no thr_hit pulse is produced.
//   - Load: count becomes d_i[c], ovf and unf become 0, and a thr_hit pulse is produced if the
//     load causes a crossing.
//   - Arithmetic: computed on WIDTH+1 bits.
//     - Up overflows when q + delta > 2^WIDTH-1.
//     - Down underflows when delta > q.
//     - Default result wraps modulo 2^WIDTH.
//   - Flags are sticky: once set, a flag holds until clear, clr_all or load on that channel.
//     Further over/underflows do not affect the flag.
//   - delta == 0 with en: count unchanged, no flag change.
//   - Threshold: thr_hit_o[c] = 1 for exactly one cycle when q_next >= thr and q_cur < thr.
//     - It is asserted in the same cycle the new count appears on q_o (registered).
//     - thr == 0 never fires.
//     - A wrap past the threshold fires only if the wrapped value is >= thr and the old value
//       was < thr.
//   - Channels are fully independent; simultaneous events on different channels never
//     interact.
//   - thr_i may change at any time; it is sampled in the same cycle as the counter update.
//
// CONFIGURATION
//   MULTI_DELTA_COUNTER_SAT_EN
//     - Defined: adds input sat_i [NUM_CH]. Channels with sat_i[c]=1 clamp instead of
//       wrapping: an overflowing up-count yields 2^WIDTH-1 and an underflowing down-count
//       yields 0. ovf/unf are still set. The thr_hit rule is applied to the clamped value.
//     - Undefined: sat_i does not exist and all channels wrap modulo 2^WIDTH.
//
// TESTING  (WIDTH=8, NUM_CH=4)
//   - Reset: assert rst_i mid-count on ch0 = 0x37 -> q_o, flags and thr_hit_o read 0 in
//     that cycle and after release.
//   - Wrap up: ch1 load 0xF0, then en, up, delta 0x20 -> q = 0x10 next cycle, ovf_o[1] = 1
//     and stays 1. A following load of 0x05 -> ovf_o[1] = 0.
//   - Wrap down: ch2 = 0x03, en, down, delta 0x05 -> q = 0xFE, unf_o[2] = 1, ovf_o[2] = 0.
//   - Priority: ch3 with clear, load 0xAA and en all set in one cycle -> q = 0. With load and
//     en only -> q = 0xAA. clr_all -> all channels 0.
//   - Threshold: thr = 0x10, ch0 counts 0x0C by +4 -> single thr_hit pulse at q = 0x10.
//     Further +4 steps give no pulse. Load 0x00, then count +0x10 -> one pulse again.
//   - SAT_EN build: sat_i[1] = 1, q = 0xF0, +0x20 -> q = 0xFF, ovf = 1. sat_i[1] = 1, q = 0x02,
//     down 0x05 -> q = 0x00, unf = 1.

Source files
------------

// File: rtl/multi_delta_counter.sv
// -----------------------------------------------------------------------------
// multi_delta_counter
//
// Purpose:
//   Bank of NUM_CH independent up/down counters. Each channel:
//     - adds or subtracts a per-cycle variable delta,
//     - keeps sticky overflow and underflow flags,
//     - emits a registered one-cycle pulse when its count crosses a
//       threshold upwards.
//
// Priority per channel, highest first:
//   clr_all_i, clear_i[c], load_i[c], en_i[c], hold.
//
// Optional build macro:
//   MULTI_DELTA_COUNTER_SAT_EN
//     When defined, adds the sat_i port. A channel with sat_i[c]=1 clamps
//     instead of wrapping: up to 2^WIDTH-1 and down to 0. The ovf/unf flags
//     are still set.
//
// Parameters:
//   NUM_CH  number of channels (>=1)
//   WIDTH   width of the counter, delta, load value and threshold
//
// Ports:
//   Slice packing for all multi-channel buses: channel c is at
//   [c*WIDTH +: WIDTH].
//
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   clr_all_i  synchronous clear of every channel and flag
//   clear_i    per-channel synchronous clear
//   load_i     per-channel load of the d_i slice
//   en_i       per-channel count enable
//   down_i     per-channel direction (1 = subtract delta)
//   sat_i      per-channel saturate enable (SAT_EN build only)
//   delta_i    per-channel delta
//   d_i        per-channel load value
//   thr_i      per-channel threshold
//   q_o        per-channel count
//   ovf_o      sticky overflow flags
//   unf_o      sticky underflow flags
//   thr_hit_o  one-cycle upward threshold-crossing pulses
// -----------------------------------------------------------------------------
module multi_delta_counter #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_all_i,
  input  logic [NUM_CH-1:0]       clear_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       down_i,
`ifdef MULTI_DELTA_COUNTER_SAT_EN
  input  logic [NUM_CH-1:0]       sat_i,
`endif
  input  logic [NUM_CH*WIDTH-1:0] delta_i,
  input  logic [NUM_CH*WIDTH-1:0] d_i,
  input  logic [NUM_CH*WIDTH-1:0] thr_i,
  output logic [NUM_CH*WIDTH-1:0] q_o,
  output logic [NUM_CH-1:0]       ovf_o,
  output logic [NUM_CH-1:0]       unf_o,
  output logic [NUM_CH-1:0]       thr_hit_o
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] q_reg, q_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             hit_reg, hit_next;
    logic [WIDTH-1:0] delta, d_val, thr;
    logic [WIDTH:0]   sum, diff;
    logic             carry, borrow, sat, crossing_ok;

    assign delta = delta_i[gi*WIDTH +: WIDTH];
    assign d_val = d_i[gi*WIDTH +: WIDTH];
    assign thr   = thr_i[gi*WIDTH +: WIDTH];

`ifdef MULTI_DELTA_COUNTER_SAT_EN
    assign sat = sat_i[gi];
`else
    assign sat = 1'b0;
`endif

    // One extra bit exposes the carry and borrow directly. For the
    // difference, the top bit is set exactly when delta > q (two's
    // complement borrow).
    assign sum    = {1'b0, q_reg} + {1'b0, delta};
    assign diff   = {1'b0, q_reg} - {1'b0, delta};
    assign carry  = sum[WIDTH];
    assign borrow = diff[WIDTH];

    always_comb begin
      q_next      = q_reg;
      ovf_next    = ovf_reg;
      unf_next    = unf_reg;
      crossing_ok = 1'b0;

      if (clr_all_i || clear_i[gi]) begin
        q_next   = '0;
        ovf_next = 1'b0;
        unf_next = 1'b0;
      end else if (load_i[gi]) begin
        q_next      = d_val;
        ovf_next    = 1'b0;
        unf_next    = 1'b0;
        crossing_ok = 1'b1;
      end else if (en_i[gi]) begin
        crossing_ok = 1'b1;
        if (down_i[gi]) begin
          q_next   = (borrow && sat) ? '0 : diff[WIDTH-1:0];
          unf_next = unf_reg | borrow;
        end else begin
          q_next   = (carry && sat) ? '1 : sum[WIDTH-1:0];
          ovf_next = ovf_reg | carry;
        end
      end

      // A threshold of 0 can never fire, because q_reg < 0 is impossible.
      // Hold and clear cycles are excluded explicitly.
      hit_next = crossing_ok && (q_next >= thr) && (q_reg < thr);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        q_reg   <= '0;
        ovf_reg <= 1'b0;
        unf_reg <= 1'b0;
        hit_reg <= 1'b0;
      end else begin
        q_reg   <= q_next;
        ovf_reg <= ovf_next;
        unf_reg <= unf_next;
        hit_reg <= hit_next;
      end
    end

    assign q_o[gi*WIDTH +: WIDTH] = q_reg;
    assign ovf_o[gi]              = ovf_reg;
    assign unf_o[gi]              = unf_reg;
    assign thr_hit_o[gi]          = hit_reg;
  end

endmodule

// File: tb/tb_multi_delta_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_delta_counter
//
// Randomised and directed stimulus for multi_delta_counter (NUM_CH=4,
// WIDTH=8). Each stimulus cycle the reference model predicts the
// registered outputs and queues them. A monitor pops one entry after every
// rising edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multi_delta_counter;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int MAXV   = (1 << WIDTH) - 1;
`ifdef MULTI_DELTA_COUNTER_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    clr_all_i;
  logic [NUM_CH-1:0]       clear_i, load_i, en_i, down_i, sat_i;
  logic [NUM_CH*WIDTH-1:0] delta_i, d_i, thr_i;
  logic [NUM_CH*WIDTH-1:0] q_o;
  logic [NUM_CH-1:0]       ovf_o, unf_o, thr_hit_o;

  multi_delta_counter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_all_i (clr_all_i),
    .clear_i   (clear_i),
    .load_i    (load_i),
    .en_i      (en_i),
    .down_i    (down_i),
`ifdef MULTI_DELTA_COUNTER_SAT_EN
    .sat_i     (sat_i),
`endif
    .delta_i   (delta_i),
    .d_i       (d_i),
    .thr_i     (thr_i),
    .q_o       (q_o),
    .ovf_o     (ovf_o),
    .unf_o     (unf_o),
    .thr_hit_o (thr_hit_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [NUM_CH*WIDTH-1:0] q;
    logic [NUM_CH-1:0]       ovf;
    logic [NUM_CH-1:0]       unf;
    logic [NUM_CH-1:0]       hit;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   txn         = 0;

  // Reference model state: plain integers and bits per channel.
  int mq[NUM_CH];
  bit movf[NUM_CH];
  bit munf[NUM_CH];

  // One stimulus cycle. Inputs are driven on the falling edge and the
  // model's prediction for the following rising edge is queued.
  task automatic step(input bit rst, input bit ca,
                      input logic [NUM_CH-1:0] clr, input logic [NUM_CH-1:0] ld,
                      input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] dn,
                      input logic [NUM_CH-1:0] sat,
                      input logic [NUM_CH*WIDTH-1:0] dl,
                      input logic [NUM_CH*WIDTH-1:0] dv,
                      input logic [NUM_CH*WIDTH-1:0] th);
    exp_t e;
    @(negedge clk_i);
    rst_i = rst; clr_all_i = ca; clear_i = clr; load_i = ld; en_i = en;
    down_i = dn; sat_i = sat; delta_i = dl; d_i = dv; thr_i = th;
    e.q = '0; e.ovf = '0; e.unf = '0; e.hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      int  q   = mq[c];
      int  nq  = q;
      int  dlt = int'(dl[c*WIDTH +: WIDTH]);
      int  thr = int'(th[c*WIDTH +: WIDTH]);
      bit  s   = SAT_BUILD && sat[c];
      bit  cnt = 1'b0;
      if (rst) begin
        nq = 0; movf[c] = 0; munf[c] = 0;
      end else if (ca || clr[c]) begin
        nq = 0; movf[c] = 0; munf[c] = 0;
      end else if (ld[c]) begin
        nq = int'(dv[c*WIDTH +: WIDTH]); movf[c] = 0; munf[c] = 0; cnt = 1'b1;
      end else if (en[c]) begin
        cnt = 1'b1;
        if (dn[c]) begin
          if (dlt > q) begin
            munf[c] = 1;
            nq = s ? 0 : q - dlt + MAXV + 1;
          end else nq = q - dlt;
        end else begin
          if (q + dlt > MAXV) begin
            movf[c] = 1;
            nq = s ? MAXV : q + dlt - (MAXV + 1);
          end else nq = q + dlt;
        end
      end
      e.hit[c] = cnt && (nq >= thr) && (q < thr);
      mq[c] = nq;
      e.q[c*WIDTH +: WIDTH] = WIDTH'(nq);
      e.ovf[c] = movf[c];
      e.unf[c] = munf[c];
    end
    sb.push_back(e);
    if (rst) begin
      // Reset is asynchronous, so the outputs must already be clear
      // before any clock edge.
      #1;
      vectors++;
      if (q_o !== '0 || ovf_o !== '0 || unf_o !== '0 || thr_hit_o !== '0) begin
        miscompares++;
        $display("FAIL async_reset: q=%h ovf=%b unf=%b hit=%b required all zero",
                 q_o, ovf_o, unf_o, thr_hit_o);
      end
    end
  endtask

  // Convenience for single-channel directed cycles.
  task automatic ch_op(input int c, input bit ld, input bit en, input bit dn,
                       input bit sat, input logic [WIDTH-1:0] dl,
                       input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] th);
    logic [NUM_CH*WIDTH-1:0] dlv, dvv, thv;
    logic [NUM_CH-1:0]       ldv, env, dnv, satv;
    dlv = '0; dvv = '0; thv = '0; ldv = '0; env = '0; dnv = '0; satv = '0;
    dlv[c*WIDTH +: WIDTH] = dl;
    dvv[c*WIDTH +: WIDTH] = dv;
    thv[c*WIDTH +: WIDTH] = th;
    ldv[c] = ld; env[c] = en; dnv[c] = dn; satv[c] = sat;
    step(1'b0, 1'b0, '0, ldv, env, dnv, satv, dlv, dvv, thv);
  endtask

  // Monitor: the DUT presents new registered outputs after every rising
  // edge, so each queued prediction is compared right after one.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        txn++;
        vectors++;
        $display("txn %0d: q=%h ovf=%b unf=%b hit=%b (model q=%h ovf=%b unf=%b hit=%b)",
                 txn, q_o, ovf_o, unf_o, thr_hit_o, e.q, e.ovf, e.unf, e.hit);
        if (q_o !== e.q || ovf_o !== e.ovf || unf_o !== e.unf || thr_hit_o !== e.hit) begin
          miscompares++;
          $display("FAIL txn_%0d: got q=%h ovf=%b unf=%b hit=%b, required q=%h ovf=%b unf=%b hit=%b",
                   txn, q_o, ovf_o, unf_o, thr_hit_o, e.q, e.ovf, e.unf, e.hit);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; clr_all_i = 1'b0; clear_i = '0; load_i = '0; en_i = '0;
    down_i = '0; sat_i = '0; delta_i = '0; d_i = '0; thr_i = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c] = 0; movf[c] = 0; munf[c] = 0;
    end

    step(1'b1, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0);

    // Reset mid-count on ch0 = 0x37.
    ch_op(0, 1, 0, 0, 0, 8'h00, 8'h37, 8'h00);
    ch_op(0, 0, 1, 0, 0, 8'h01, 8'h00, 8'h00);
    step(1'b1, 1'b0, '0, '0, 4'b0001, '0, '0, 32'h0000_0001, '0, '0);
    step(1'b1, 1'b0, '0, '0, 4'b0001, '0, '0, 32'h0000_0001, '0, '0);
    ch_op(0, 0, 1, 0, 0, 8'h01, 8'h00, 8'h00);

    // Wrap up on ch1, sticky ovf, then load clears it.
    ch_op(1, 1, 0, 0, 0, 8'h00, 8'hF0, 8'h00);
    ch_op(1, 0, 1, 0, 0, 8'h20, 8'h00, 8'h00);
    ch_op(1, 0, 1, 0, 0, 8'h01, 8'h00, 8'h00);
    ch_op(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    ch_op(1, 1, 0, 0, 0, 8'h00, 8'h05, 8'h00);

    // Wrap down on ch2.
    ch_op(2, 1, 0, 0, 0, 8'h00, 8'h03, 8'h00);
    ch_op(2, 0, 1, 1, 0, 8'h05, 8'h00, 8'h00);
    ch_op(2, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00);

    // Priority on ch3, then clr_all.
    step(1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1000, '0, '0,
         32'h0100_0000, 32'hAA00_0000, '0);
    step(1'b0, 1'b0, '0, 4'b1000, 4'b1000, '0, '0,
         32'h0100_0000, 32'hAA00_0000, '0);
    step(1'b0, 1'b1, 4'b0000, 4'b1111, 4'b1111, '0, '0,
         32'h0101_0101, 32'h1122_3344, '0);

    // Threshold crossing on ch0.
    ch_op(0, 1, 0, 0, 0, 8'h00, 8'h0C, 8'h10);
    for (int i = 0; i < 3; i++) ch_op(0, 0, 1, 0, 0, 8'h04, 8'h00, 8'h10);
    ch_op(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h10);
    ch_op(0, 0, 1, 0, 0, 8'h10, 8'h00, 8'h10);

    // Saturation (only clamps in the SAT_EN build; the model follows suit).
    ch_op(1, 1, 0, 0, 1, 8'h00, 8'hF0, 8'h00);
    ch_op(1, 0, 1, 0, 1, 8'h20, 8'h00, 8'h00);
    ch_op(1, 1, 0, 0, 1, 8'h00, 8'h02, 8'h00);
    ch_op(1, 0, 1, 1, 1, 8'h05, 8'h00, 8'h00);

    // Random traffic across all channels.
    for (int i = 0; i < 400; i++) begin
      logic [NUM_CH-1:0]       clr, ld, en, dn, sat;
      logic [NUM_CH*WIDTH-1:0] dl, dv, th;
      bit                      rst, ca;
      rst = ($urandom_range(0, 99) == 0);
      ca  = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        clr[c] = ($urandom_range(0, 19) == 0);
        ld[c]  = ($urandom_range(0, 7) == 0);
        en[c]  = ($urandom_range(0, 1) == 1);
        dn[c]  = ($urandom_range(0, 1) == 1);
        sat[c] = ($urandom_range(0, 1) == 1);
        dl[c*WIDTH +: WIDTH] = ($urandom_range(0, 7) == 0) ? 8'h00 : WIDTH'($urandom);
        dv[c*WIDTH +: WIDTH] = WIDTH'($urandom);
        th[c*WIDTH +: WIDTH] = ($urandom_range(0, 9) == 0) ? 8'h00 : WIDTH'($urandom);
      end
      step(rst, ca, clr, ld, en, dn, sat, dl, dv, th);
    end

    @(negedge clk_i);
    rst_i = 1'b0; clr_all_i = 1'b0; clear_i = '0; load_i = '0; en_i = '0;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_i);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
